uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a small receive FIFO
// and sticky error flags. The serial input is double-flopped before any use.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx_wire,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic                          parity_err,
`endif
    input  logic                          err_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic sync1_reg, sync2_reg, prev_reg;
    logic rx_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= uart_rx_wire;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rx_line = sync2_reg;

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  bit_reg, bit_next;
    logic [7:0]  shift_reg, shift_next;
    logic        push_reg, push_next;
    logic        frame_set;
`ifdef UART_RX_PARITY_EN
    logic        par_bad_reg, par_bad_next;
    logic        parity_set;
    logic        parity_err_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            push_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            push_reg  <= push_next;
`ifdef UART_RX_PARITY_EN
            par_bad_reg <= par_bad_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 16'd1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        push_next  = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_next = par_bad_reg;
        parity_set   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                // Falling edge only: a line held low after a bad stop bit cannot retrigger.
                if (prev_reg && !rx_line) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_line ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
                    par_bad_next = 1'b0;
`endif
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rx_line, shift_reg[7:1]};
                    bit_next   = bit_reg + 3'd1;
                    if (bit_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    par_bad_next = (rx_line != ^shift_reg);
                    parity_set   = (rx_line != ^shift_reg);
                    state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    frame_set  = !rx_line;
`ifdef UART_RX_PARITY_EN
                    push_next  = rx_line && !par_bad_reg;
`else
                    push_next  = rx_line;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Receive FIFO; the assembled byte stays in shift_reg during the cycle after the stop sample.
    logic [7:0]    mem_reg [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          pop, full, wr_en, overrun_set;

    assign pop         = rx_ready && (count_reg != '0);
    assign full        = (count_reg == FULL_CNT);
    assign wr_en       = push_reg && (!full || pop);
    assign overrun_set = push_reg && full && !pop;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && (wr_ptr_reg == AW'(gi))) begin
                    mem_reg[gi] <= shift_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)   rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({wr_en, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    logic frame_err_reg, overrun_err_reg;

    // A new error event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_reg   <= 1'b0;
            overrun_err_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg  <= 1'b0;
`endif
        end else begin
            frame_err_reg   <= frame_set   | (frame_err_reg   & ~err_clr);
            overrun_err_reg <= overrun_set | (overrun_err_reg & ~err_clr);
`ifdef UART_RX_PARITY_EN
            parity_err_reg  <= parity_set  | (parity_err_reg  & ~err_clr);
`endif
        end
    end

    assign rx_data     = mem_reg[rd_ptr_reg];
    assign rx_valid    = (count_reg != '0);
    assign fifo_count  = count_reg;
    assign frame_err   = frame_err_reg;
    assign overrun_err = overrun_err_reg;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (CLKS_PER_BIT=16, FIFO_DEPTH=4); expected bytes go through a queue
// when frames are sent and are compared as they are popped.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int NOM_RISE = (NBITS - 1) * CPB + CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx_wire = 1'b1;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .uart_rx_wire (uart_rx_wire),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .fifo_count   (fifo_count),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err),
`ifdef UART_RX_PARITY_EN
        .parity_err   (parity_err),
`endif
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         rise_cycle;
    int         t1_rise;
    logic [7:0] exp_q[$];
    logic [7:0] head;
    logic [7:0] d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Drives the first nbits bits of a frame, one per CPB clocks, starting at a falling clk edge.
    // rise_cycle records the first sampled cycle with rx_valid high; pop_at pulses rx_ready.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_bit,
                              input int nbits, input int pop_at);
        logic [10:0] bits;
        int cycle;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = data;
`ifdef UART_RX_PARITY_EN
        bits[9]  = par_bit;
        bits[10] = stop_bit;
`else
        bits[9]  = stop_bit;
        bits[10] = par_bit | 1'b1;
`endif
        cycle = 0;
        rise_cycle = -1;
        for (int b = 0; b < nbits; b++) begin
            uart_rx_wire = bits[b];
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                cycle++;
                if (cycle == pop_at) rx_ready = 1'b1;
                else if (cycle == pop_at + 1) rx_ready = 1'b0;
                if (rise_cycle < 0 && rx_valid) rise_cycle = cycle;
            end
        end
        rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        uart_rx_wire = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        exp = 8'hxx;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        check({tag, "_valid"}, rx_valid, 1);
        check(tag, rx_data, exp);
        $display("pop %s: rx_data=0x%02h expected=0x%02h", tag, rx_data, exp);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", rx_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun_err", overrun_err, 0);
        rst_n = 1'b1;
        idle(5);

        // Single byte, latency of rx_valid relative to the start edge
        send_frame(8'h55, 1'b1, 1'b0, NBITS, -1);
        exp_q.push_back(8'h55);
        t1_rise = rise_cycle;
        $display("frame 0x55: rx_valid rose at cycle %0d", rise_cycle);
        idle(4);
        check("t1_latency", (rise_cycle >= NOM_RISE) && (rise_cycle <= NOM_RISE + 6), 1);
        check("t1_count", fifo_count, 1);
        check("t1_frame_err", frame_err, 0);
        check("t1_overrun_err", overrun_err, 0);
        pop_check("t1_data");
        check("t1_count_after_pop", fifo_count, 0);

        // Short low glitch must be rejected as a false start
        uart_rx_wire = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        $display("glitch: fifo_count=%0d frame_err=%0b", fifo_count, frame_err);
        check("t2_count", fifo_count, 0);
        check("t2_valid", rx_valid, 0);
        check("t2_frame_err", frame_err, 0);
        send_frame(8'hA3, 1'b1, ^8'hA3, NBITS, -1);
        exp_q.push_back(8'hA3);
        idle(4);
        pop_check("t2_data");

        // Bad stop bit
        send_frame(8'h3C, 1'b0, ^8'h3C, NBITS, -1);
        idle(4);
        $display("bad stop 0x3C: frame_err=%0b fifo_count=%0d", frame_err, fifo_count);
        check("t3_frame_err", frame_err, 1);
        check("t3_count", fifo_count, 0);
        clear_errors();
        check("t3_frame_err_clr", frame_err, 0);

        // Overrun: five bytes into a four-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            send_frame(d, 1'b1, ^d, NBITS, -1);
            if (i <= DEPTH) exp_q.push_back(d);
            idle(2);
        end
        $display("overrun: fifo_count=%0d overrun_err=%0b", fifo_count, overrun_err);
        check("t4_count_full", fifo_count, 4);
        check("t4_overrun_err", overrun_err, 1);
        check("t4_frame_err", frame_err, 0);
        for (int i = 0; i < DEPTH; i++) pop_check("t4_order");
        check("t4_count_empty", fifo_count, 0);
        clear_errors();
        check("t4_overrun_clr", overrun_err, 0);

        // Refill, then pop in the same cycle the next byte is pushed
        for (int i = 6; i <= 9; i++) begin
            d = 8'(i);
            send_frame(d, 1'b1, ^d, NBITS, -1);
            exp_q.push_back(d);
            idle(2);
        end
        check("t4_refill_count", fifo_count, 4);
        head = exp_q.pop_front();
        check("t4_head", rx_data, head);
        exp_q.push_back(8'h0A);
        send_frame(8'h0A, 1'b1, ^8'h0A, NBITS, t1_rise - 1);
        idle(4);
        $display("push+pop at full: fifo_count=%0d overrun_err=%0b", fifo_count, overrun_err);
        check("t4_simul_count", fifo_count, 4);
        check("t4_simul_overrun", overrun_err, 0);
        for (int i = 0; i < DEPTH; i++) pop_check("t4_simul_order");

        // Reset in the middle of a frame
        send_frame(8'h11, 1'b1, ^8'h11, NBITS, -1);
        exp_q.push_back(8'h11);
        idle(4);
        check("t5_pre_count", fifo_count, 1);
        send_frame(8'hF0, 1'b1, 1'b0, 5, -1);
        rst_n = 1'b0;
        #1;
        $display("mid-frame reset: fifo_count=%0d rx_valid=%0b rx_data=0x%02h", fifo_count, rx_valid, rx_data);
        check("t5_rst_count", fifo_count, 0);
        check("t5_rst_valid", rx_valid, 0);
        check("t5_rst_data", rx_data, 0);
        check("t5_rst_frame_err", frame_err, 0);
        check("t5_rst_overrun_err", overrun_err, 0);
        exp_q.delete();
        @(negedge clk);
        uart_rx_wire = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(CPB * (NBITS + 2));
        check("t5_release_count", fifo_count, 0);
        check("t5_release_frame_err", frame_err, 0);
        send_frame(8'h7E, 1'b1, ^8'h7E, NBITS, -1);
        exp_q.push_back(8'h7E);
        idle(4);
        check("t5_count", fifo_count, 1);
        pop_check("t5_data");

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the parity bit must be 1
        send_frame(8'h07, 1'b1, 1'b1, NBITS, -1);
        exp_q.push_back(8'h07);
        idle(4);
        check("t6_good_count", fifo_count, 1);
        check("t6_good_parity_err", parity_err, 0);
        send_frame(8'h07, 1'b1, 1'b0, NBITS, -1);
        idle(4);
        $display("bad parity 0x07: parity_err=%0b fifo_count=%0d", parity_err, fifo_count);
        check("t6_bad_parity_err", parity_err, 1);
        check("t6_bad_count", fifo_count, 1);
        check("t6_bad_frame_err", frame_err, 0);
        pop_check("t6_data");
        clear_errors();
        check("t6_parity_clr", parity_err, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
